gpr_wb_ctrl: RTL and testbench

GPR_WB_CTRL -- requirements
Module: gpr_wb_ctrl

---
 rtl/gpr_wb_ctrl.sv | 117 +++++++++++
 tb/tb_gpr_wb_ctrl.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/gpr_wb_ctrl.sv
// gpr_wb_ctrl: GPR write-back arbiter. Load returns have priority; ALU
// results that cannot be written immediately are held in a small circular
// skid FIFO and drained in acceptance order. The write port is registered.
// Optional feature: define GPR_WB_FWD_EN to add a write-port forwarding
// lookup (fwd_raddr -> fwd_hit/fwd_data).
module gpr_wb_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 2   // 2 or 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  alu_vld,
  output logic                  alu_rdy,
  input  logic [4:0]            alu_rd,
  input  logic [DATA_WIDTH-1:0] alu_data,
  input  logic                  lsu_vld,
  input  logic [4:0]            lsu_rd,
  input  logic [DATA_WIDTH-1:0] lsu_data,
  output logic                  gpr_wen,
  output logic [4:0]            gpr_waddr,
  output logic [DATA_WIDTH-1:0] gpr_wdata,
  output logic [2:0]            wb_cnt
`ifdef GPR_WB_FWD_EN
  ,
  input  logic [4:0]            fwd_raddr,
  output logic                  fwd_hit,
  output logic [DATA_WIDTH-1:0] fwd_data
`endif
);

  localparam int         PTR_W = (FIFO_DEPTH > 2) ? 2 : 1;
  localparam logic [2:0] DEPTH = 3'(FIFO_DEPTH);

  typedef struct packed {
    logic [4:0]            rd;
    logic [DATA_WIDTH-1:0] data;
  } wb_ent_t;

  wb_ent_t          mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;

  logic    empty, acc, pop, pass, push, sel_vld;
  wb_ent_t sel, alu_ent;

  // Ready depends only on registered occupancy; a pop in a full cycle does
  // not open the slot until the next cycle.
  assign alu_rdy = (wb_cnt < DEPTH);

  // Source selection: load > FIFO head > direct ALU pass-through.
  always_comb begin
    empty   = (wb_cnt == 3'd0);
    acc     = alu_vld & alu_rdy;
    pop     = ~lsu_vld & ~empty;
    pass    = acc & empty & ~lsu_vld;
    push    = acc & ~pass;
    alu_ent = '{rd: alu_rd, data: alu_data};
    sel_vld = 1'b0;
    sel     = alu_ent;
    if (lsu_vld) begin
      sel_vld = 1'b1;
      sel     = '{rd: lsu_rd, data: lsu_data};
    end else if (!empty) begin
      sel_vld = 1'b1;
      sel     = mem[rd_ptr];
    end else if (pass) begin
      sel_vld = 1'b1;
      sel     = alu_ent;
    end
  end

  // FIFO storage: data only, no reset needed.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= alu_ent;
  end

  // FIFO pointers and occupancy; pointers wrap naturally at FIFO_DEPTH.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      wb_cnt <= 3'd0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   wb_cnt <= wb_cnt + 3'd1;
        2'b01:   wb_cnt <= wb_cnt - 3'd1;
        default: wb_cnt <= wb_cnt;
      endcase
    end
  end

  // Registered write port; x0 writes are consumed but never enabled, and
  // address/data hold when nothing is selected.
  always_ff @(posedge clk) begin
    if (rst) begin
      gpr_wen   <= 1'b0;
      gpr_waddr <= 5'd0;
      gpr_wdata <= '0;
    end else begin
      gpr_wen <= sel_vld & (sel.rd != 5'd0);
      if (sel_vld) begin
        gpr_waddr <= sel.rd;
        gpr_wdata <= sel.data;
      end
    end
  end

`ifdef GPR_WB_FWD_EN
  // Forwarding lookup straight off the registered write port.
  always_comb begin
    fwd_hit  = gpr_wen & (gpr_waddr == fwd_raddr) & (fwd_raddr != 5'd0);
    fwd_data = gpr_wdata;
  end
`endif

endmodule

// File: tb/tb_gpr_wb_ctrl.sv
// Directed bench for gpr_wb_ctrl (default FIFO_DEPTH=2, DATA_WIDTH=32).
module tb_gpr_wb_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        alu_vld, lsu_vld;
  logic        alu_rdy;
  logic [4:0]  alu_rd, lsu_rd;
  logic [31:0] alu_data, lsu_data;
  logic        gpr_wen;
  logic [4:0]  gpr_waddr;
  logic [31:0] gpr_wdata;
  logic [2:0]  wb_cnt;
`ifdef GPR_WB_FWD_EN
  logic [4:0]  fwd_raddr;
  logic        fwd_hit;
  logic [31:0] fwd_data;
`endif

  int total = 0;
  int bad   = 0;

  gpr_wb_ctrl #(.DATA_WIDTH(32), .FIFO_DEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .alu_vld(alu_vld), .alu_rdy(alu_rdy), .alu_rd(alu_rd), .alu_data(alu_data),
    .lsu_vld(lsu_vld), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
    .gpr_wen(gpr_wen), .gpr_waddr(gpr_waddr), .gpr_wdata(gpr_wdata),
    .wb_cnt(wb_cnt)
`ifdef GPR_WB_FWD_EN
    , .fwd_raddr(fwd_raddr), .fwd_hit(fwd_hit), .fwd_data(fwd_data)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Outputs are sampled 1ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic alu(input logic v, input logic [4:0] rd, input logic [31:0] d);
    alu_vld = v; alu_rd = rd; alu_data = d;
  endtask

  task automatic lsu(input logic v, input logic [4:0] rd, input logic [31:0] d);
    lsu_vld = v; lsu_rd = rd; lsu_data = d;
  endtask

  task automatic wport(input string tag, input logic wen, input logic [4:0] a, input logic [31:0] d);
    chk({tag, "_wen"}, 32'(gpr_wen), 32'(wen));
    if (wen) begin
      chk({tag, "_waddr"}, 32'(gpr_waddr), 32'(a));
      chk({tag, "_wdata"}, gpr_wdata, d);
    end
  endtask

  initial begin
    rst = 1'b1;
    alu(0, 0, 0);
    lsu(0, 0, 0);
`ifdef GPR_WB_FWD_EN
    fwd_raddr = 5'd0;
`endif
    tick(); tick();
    rst = 1'b0;
    chk("rst_wen",   32'(gpr_wen),   0);
    chk("rst_waddr", 32'(gpr_waddr), 0);
    chk("rst_wdata", gpr_wdata,      0);
    chk("rst_cnt",   32'(wb_cnt),    0);
    chk("rst_rdy",   32'(alu_rdy),   1);

    // Pass-through
    alu(1, 5, 32'h1234);
    tick();
    alu(0, 0, 0);
    wport("pass", 1, 5, 32'h1234);
    chk("pass_cnt", 32'(wb_cnt), 0);

    // Idle: wen drops, address/data hold
    tick();
    chk("idle_wen",   32'(gpr_wen),   0);
    chk("idle_waddr", 32'(gpr_waddr), 5);
    chk("idle_wdata", gpr_wdata,      32'h1234);

    // Collision: load first, ALU buffered
    lsu(1, 3, 32'hAAAA);
    alu(1, 4, 32'hBBBB);
    tick();
    lsu(0, 0, 0);
    alu(0, 0, 0);
    wport("col1", 1, 3, 32'hAAAA);
    chk("col1_cnt", 32'(wb_cnt), 1);
    tick();
    wport("col2", 1, 4, 32'hBBBB);
    chk("col2_cnt", 32'(wb_cnt), 0);

    // Full: load held for 3 cycles while ALU keeps offering
    lsu(1, 10, 32'h10);
    alu(1, 11, 32'h11);
    tick();
    wport("full1", 1, 10, 32'h10);
    chk("full1_cnt", 32'(wb_cnt), 1);
    chk("full1_rdy", 32'(alu_rdy), 1);
    alu(1, 12, 32'h12);
    tick();
    chk("full2_cnt", 32'(wb_cnt), 2);
    chk("full2_rdy", 32'(alu_rdy), 0);
    alu(1, 13, 32'h13);
    tick();
    wport("full3", 1, 10, 32'h10);
    chk("full3_cnt", 32'(wb_cnt), 2);
    chk("full3_rdy", 32'(alu_rdy), 0);
    lsu(0, 0, 0);
    alu(0, 0, 0);
    tick();
    wport("drain1", 1, 11, 32'h11);
    chk("drain1_cnt", 32'(wb_cnt), 1);
    tick();
    wport("drain2", 1, 12, 32'h12);
    chk("drain2_cnt", 32'(wb_cnt), 0);
    chk("drain2_rdy", 32'(alu_rdy), 1);

    // x0 drop via pass-through, then normal write
    alu(1, 0, 32'hFFFF);
    tick();
    chk("x0_wen", 32'(gpr_wen), 0);
    alu(1, 7, 32'h77);
    tick();
    alu(0, 0, 0);
    wport("x7", 1, 7, 32'h77);

    // x0 drop from the buffer (pointers have wrapped by now)
    lsu(1, 2, 32'h22);
    alu(1, 0, 32'h5555);
    tick();
    lsu(0, 0, 0);
    alu(0, 0, 0);
    wport("x0b_lsu", 1, 2, 32'h22);
    chk("x0b_cnt1", 32'(wb_cnt), 1);
    tick();
    chk("x0b_wen", 32'(gpr_wen), 0);
    chk("x0b_cnt0", 32'(wb_cnt), 0);

    // Reset mid-drain
    lsu(1, 20, 32'h20);
    alu(1, 21, 32'h21);
    tick();
    alu(1, 22, 32'h22);
    tick();
    lsu(0, 0, 0);
    alu(0, 0, 0);
    chk("prerst_cnt", 32'(wb_cnt), 2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst_cnt",   32'(wb_cnt),    0);
    chk("mrst_rdy",   32'(alu_rdy),   1);
    chk("mrst_wen",   32'(gpr_wen),   0);
    chk("mrst_waddr", 32'(gpr_waddr), 0);
    tick();
    chk("mrst_wen2", 32'(gpr_wen), 0);
    chk("mrst_cnt2", 32'(wb_cnt),  0);
    tick();
    chk("mrst_wen3", 32'(gpr_wen), 0);

`ifdef GPR_WB_FWD_EN
    alu(1, 9, 32'h99);
    fwd_raddr = 5'd9;
    tick();
    alu(0, 0, 0);
    chk("fwd_hit",  32'(fwd_hit), 1);
    chk("fwd_data", fwd_data,     32'h99);
    fwd_raddr = 5'd0;
    #1;
    chk("fwd_x0", 32'(fwd_hit), 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
